// File: rtl/panel_pkg.sv
// ============================================================================
// panel_pkg: shared constants, scan state encoding and PWM step helper.
// Rev 1.0. Brightness states exist only with PANEL_BRIGHTNESS_LOAD_EN.
// ============================================================================
`default_nettype none

package panel_pkg;

  localparam int PWM_W        = 8;
  localparam int SR_WIDTH_DEF = 16;
  localparam int CLK_DIV_DEF  = 1;
  localparam int PWM_MAX_DEF  = 255;

`ifdef PANEL_BRIGHTNESS_LOAD_EN
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LOAD    = 4'd1,
    ST_BIT_LO  = 4'd2,
    ST_BIT_HI  = 4'd3,
    ST_LATCH   = 4'd4,
    ST_ADVANCE = 4'd5,
    ST_BLOAD   = 4'd6,
    ST_BBIT_LO = 4'd7,
    ST_BBIT_HI = 4'd8,
    ST_BLATCH  = 4'd9
  } scan_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_BIT_LO  = 3'd2,
    ST_BIT_HI  = 3'd3,
    ST_LATCH   = 3'd4,
    ST_ADVANCE = 3'd5
  } scan_state_e;
`endif

  // Time base step: wraps to zero after the last value instead of carrying out.
  function automatic logic [PWM_W-1:0] pwm_next(input logic [PWM_W-1:0] t,
                                                input logic [PWM_W-1:0] last);
    return (t == last) ? '0 : t + PWM_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/scan_bit_timer.sv
// ============================================================================
// scan_bit_timer: sclk half-period divider and per-word bit counter.
// Rev 1.0.
// ============================================================================
`default_nettype none

module scan_bit_timer
  import panel_pkg::*;
#(
  parameter int SR_WIDTH = SR_WIDTH_DEF,
  parameter int CLK_DIV  = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic run_i,
  input  logic bit_step_i,
  output logic half_done_o,
  output logic word_done_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SR_WIDTH - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;

  assign half_done_o = run_i && (div_q == DIV_LAST);
  assign word_done_o = (bit_q == BIT_LAST);

  always_comb begin
    div_d = div_q;
    bit_d = bit_q;
    // Divider restarts at every half boundary so LO and HI phases stay equal.
    if (!run_i || half_done_o) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    if (clear_i) begin
      bit_d = '0;
    end else if (bit_step_i && !word_done_o) begin
      bit_d = bit_q + BIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      bit_q <= '0;
    end else begin
      div_q <= div_d;
      bit_q <= bit_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/panel_scan_controller.sv
// ============================================================================
// panel_scan_controller: steps the PWM time base and sequences load/shift/
// sclk/xlat per word. Rev 1.0. Optional macro: PANEL_BRIGHTNESS_LOAD_EN.
// ============================================================================
`default_nettype none

module panel_scan_controller
  import panel_pkg::*;
#(
  parameter int SR_WIDTH = SR_WIDTH_DEF,
  parameter int PWM_MAX  = PWM_MAX_DEF,
  parameter int CLK_DIV  = CLK_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [PWM_W-1:0] pwm_time,
  output logic             load_led_vals,
  output logic             load_brightness,
  output logic             shift,
  output logic             sclk,
  output logic             xlat,
  output logic             blank,
  output logic             mode_sel,
  output logic             frame_start,
  output logic             busy
);

  localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(PWM_MAX);

  scan_state_e      state_q, state_d;
  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic             half_done;
  logic             word_done;
  logic             timer_clear;
  logic             timer_run;
  logic             bit_step;

  scan_bit_timer #(
    .SR_WIDTH (SR_WIDTH),
    .CLK_DIV  (CLK_DIV)
  ) u_bit_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (timer_clear),
    .run_i       (timer_run),
    .bit_step_i  (bit_step),
    .half_done_o (half_done),
    .word_done_o (word_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pwm_q   <= '0;
    end else begin
      state_q <= state_d;
      pwm_q   <= pwm_d;
    end
  end

  // Outputs decode from state so an async reset clears them in the same cycle.
  always_comb begin
    state_d         = state_q;
    pwm_d           = pwm_q;
    load_led_vals   = 1'b0;
    load_brightness = 1'b0;
    shift           = 1'b0;
    sclk            = 1'b0;
    xlat            = 1'b0;
    blank           = 1'b0;
    mode_sel        = 1'b0;
    frame_start     = 1'b0;
    timer_clear     = 1'b0;
    timer_run       = 1'b0;
    bit_step        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        blank = 1'b1;
        if (enable) begin
          state_d = ST_LOAD;
`ifdef PANEL_BRIGHTNESS_LOAD_EN
          if (pwm_q == '0) state_d = ST_BLOAD;
`endif
        end
      end

      ST_LOAD: begin
        load_led_vals = 1'b1;
        timer_clear   = 1'b1;
        state_d       = ST_BIT_LO;
      end

      ST_BIT_LO: begin
        timer_run = 1'b1;
        if (half_done) state_d = ST_BIT_HI;
      end

      ST_BIT_HI: begin
        sclk      = 1'b1;
        timer_run = 1'b1;
        if (half_done) begin
          shift    = 1'b1;
          bit_step = 1'b1;
          state_d  = word_done ? ST_LATCH : ST_BIT_LO;
        end
      end

      ST_LATCH: begin
        xlat    = 1'b1;
        state_d = ST_ADVANCE;
      end

      ST_ADVANCE: begin
        pwm_d       = pwm_next(pwm_q, PWM_LAST);
        frame_start = (pwm_q == PWM_LAST);
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOAD;
`ifdef PANEL_BRIGHTNESS_LOAD_EN
          if (pwm_q == PWM_LAST) state_d = ST_BLOAD;
`endif
        end
      end

`ifdef PANEL_BRIGHTNESS_LOAD_EN
      ST_BLOAD: begin
        load_brightness = 1'b1;
        mode_sel        = 1'b1;
        timer_clear     = 1'b1;
        state_d         = ST_BBIT_LO;
      end

      ST_BBIT_LO: begin
        mode_sel  = 1'b1;
        timer_run = 1'b1;
        if (half_done) state_d = ST_BBIT_HI;
      end

      ST_BBIT_HI: begin
        mode_sel  = 1'b1;
        sclk      = 1'b1;
        timer_run = 1'b1;
        if (half_done) begin
          shift    = 1'b1;
          bit_step = 1'b1;
          state_d  = word_done ? ST_BLATCH : ST_BBIT_LO;
        end
      end

      // Grayscale word for pwm_time 0 follows directly; time base is not stepped.
      ST_BLATCH: begin
        mode_sel = 1'b1;
        xlat     = 1'b1;
        state_d  = ST_LOAD;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign pwm_time = pwm_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_panel_scan_controller.sv
// ============================================================================
// tb_panel_scan_controller: randomized bench with an offset-based step model.
// Rev 1.0. Honours PANEL_BRIGHTNESS_LOAD_EN (runs CLK_DIV=2 when defined).
// ============================================================================
`default_nettype none

module tb_panel_scan_controller;

`ifdef PANEL_BRIGHTNESS_LOAD_EN
  localparam int CDIV   = 2;
  localparam bit BRIGHT = 1'b1;
`else
  localparam int CDIV   = 1;
  localparam bit BRIGHT = 1'b0;
`endif
  localparam int SRW   = 16;
  localparam int PMAX  = 255;
  localparam int NBITC = 2 * SRW * CDIV;
  localparam int STEP  = 3 + NBITC;
  localparam int BSTEP = 2 + NBITC;
  localparam int FRAME = (PMAX + 1) * STEP + (BRIGHT ? BSTEP : 0);
  localparam logic [16:0] RST_VEC = 17'h00008;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable  = 1'b0;
  logic [7:0] pwm_time;
  logic       load_led_vals, load_brightness, shift, sclk, xlat;
  logic       blank, mode_sel, frame_start, busy;

  panel_scan_controller #(
    .SR_WIDTH (SRW),
    .PWM_MAX  (PMAX),
    .CLK_DIV  (CDIV)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .pwm_time        (pwm_time),
    .load_led_vals   (load_led_vals),
    .load_brightness (load_brightness),
    .shift           (shift),
    .sclk            (sclk),
    .xlat            (xlat),
    .blank           (blank),
    .mode_sel        (mode_sel),
    .frame_start     (frame_start),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: position inside the current word pass plus the time base.
  bit m_act = 1'b0;
  bit m_bp  = 1'b0;
  int m_off = 0;
  int m_pwm = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_act <= 1'b0;
      m_bp  <= 1'b0;
      m_off <= 0;
      m_pwm <= 0;
    end else if (!m_act) begin
      if (enable) begin
        m_act <= 1'b1;
        m_off <= 0;
        m_bp  <= BRIGHT && (m_pwm == 0);
      end
    end else if (m_bp) begin
      if (m_off == BSTEP - 1) begin
        m_bp  <= 1'b0;
        m_off <= 0;
      end else begin
        m_off <= m_off + 1;
      end
    end else if (m_off == STEP - 1) begin
      m_pwm <= (m_pwm == PMAX) ? 0 : m_pwm + 1;
      m_off <= 0;
      m_act <= enable;
      m_bp  <= enable && BRIGHT && (m_pwm == PMAX);
    end else begin
      m_off <= m_off + 1;
    end
  end

  function automatic logic [16:0] model_vec();
    int   q;
    logic ld, lb, sh, sc, xl, fs;
    logic [7:0] p;
    ld = 1'b0; lb = 1'b0; sh = 1'b0; sc = 1'b0; xl = 1'b0; fs = 1'b0;
    p  = m_pwm[7:0];
    if (m_act) begin
      if (m_off == 0) begin
        if (m_bp) lb = 1'b1; else ld = 1'b1;
      end else if (m_off <= NBITC) begin
        q  = m_off - 1;
        sc = ((q / CDIV) % 2) == 1;
        sh = sc && ((q % CDIV) == CDIV - 1);
      end else if (m_off == NBITC + 1) begin
        xl = 1'b1;
      end else begin
        fs = (m_pwm == PMAX);
      end
    end
    return {p, ld, lb, sh, sc, xl, !m_act, m_act && m_bp, fs, m_act};
  endfunction

  logic [16:0] dut_vec;
  assign dut_vec = {pwm_time, load_led_vals, load_brightness, shift, sclk, xlat,
                    blank, mode_sel, frame_start, busy};

  bit   chk_en    = 1'b0;
  int   xlat_cnt  = 0;
  int   w_shift   = 0;
  int   w_rise    = 0;
  logic prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("trace", 32'(dut_vec), 32'(model_vec()));
      check("strobe_excl",
            32'($countones({load_led_vals, load_brightness, shift, xlat}) <= 1), 32'd1);
    end
    if (load_led_vals || load_brightness) begin
      w_shift = 0;
      w_rise  = 0;
    end
    if (shift) w_shift++;
    if (sclk && !prev_sclk) w_rise++;
    prev_sclk = sclk;
    if (xlat) xlat_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_for(input int which, input int limit, input string tag, output int at);
    logic hit;
    hit = 1'b0;
    at  = -1;
    for (int i = 0; i < limit && !hit; i++) begin
      tick();
      case (which)
        0:       hit = load_led_vals;
        1:       hit = xlat;
        2:       hit = frame_start;
        3:       hit = load_brightness;
        default: hit = !busy;
      endcase
    end
    if (hit) at = cyc;
    check({tag, "_seen"}, 32'(hit), 32'd1);
  endtask

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, t0, t1, t2, f1, f2, s, p0, x0;

    #1 reset_n = 1'b0;
    repeat (3) tick();
    check("reset_vec", 32'(dut_vec), 32'(RST_VEC));
    reset_n = 1'b1;
    chk_en  = 1'b1;

    s = 0;
    repeat (100) begin
      tick();
      if (load_led_vals | load_brightness | shift | xlat | frame_start) s++;
    end
    check("idle_strobes", 32'(s), 32'd0);
    check("idle_blank", 32'(blank), 32'd1);
    check("idle_pwm", 32'(pwm_time), 32'd0);

    // First word after enable, including the brightness pass when present.
    e      = cyc;
    enable = 1'b1;
`ifdef PANEL_BRIGHTNESS_LOAD_EN
    wait_for(3, 10, "first_bload", t0);
    check("first_bload_lat", 32'(t0 - e), 32'd1);
    check("bload_mode_sel", 32'(mode_sel), 32'd1);
    wait_for(1, BSTEP + 2, "blatch", t2);
    check("bpass_shifts", 32'(w_shift), 32'(SRW));
    check("bpass_sclk_rises", 32'(w_rise), 32'(SRW));
    tick();
    check("load_after_blatch", 32'(load_led_vals), 32'd1);
    check("load_after_blatch_pwm", 32'(pwm_time), 32'd0);
    t1 = cyc;
`else
    wait_for(0, 10, "first_load", t1);
    check("first_load_lat", 32'(t1 - e), 32'd1);
`endif
    wait_for(1, STEP + 2, "first_xlat", t2);
    check("word_shifts", 32'(w_shift), 32'(SRW));
    check("word_sclk_rises", 32'(w_rise), 32'(SRW));
    wait_for(0, STEP + 2, "second_load", t2);
    check("step_period", 32'(t2 - t1), 32'(STEP));
    check("second_load_pwm", 32'(pwm_time), 32'd1);

    // Wrap and frame period.
    wait_for(2, FRAME + STEP, "frame_start_a", f1);
    check("wrap_pwm_before", 32'(pwm_time), 32'(PMAX));
    tick();
    check("wrap_pwm_after", 32'(pwm_time), 32'd0);
`ifdef PANEL_BRIGHTNESS_LOAD_EN
    check("bload_after_wrap", 32'(load_brightness), 32'd1);
`else
    check("load_after_wrap", 32'(load_led_vals), 32'd1);
`endif
    wait_for(2, FRAME + 10, "frame_start_b", f2);
    check("frame_period", 32'(f2 - f1), 32'(FRAME));

    // Deassert enable at bit 7: word completes, one latch, one increment.
    wait_for(0, STEP + BSTEP + 2, "disable_load", t0);
    repeat (1 + 14 * CDIV) tick();
    enable = 1'b0;
    p0 = int'(pwm_time);
    x0 = xlat_cnt;
    wait_for(4, STEP + 2, "idle_after_disable", t1);
    check("disable_xlats", 32'(xlat_cnt - x0), 32'd1);
    check("disable_pwm_inc", 32'(pwm_time), 32'((p0 + 1) % (PMAX + 1)));
    check("disable_blank", 32'(blank), 32'd1);

    // Reset at bit 10: immediate reset outputs, partial word never latched.
    enable = 1'b1;
    wait_for(0, STEP + BSTEP + 2, "reset_load", t0);
    repeat (1 + 20 * CDIV) tick();
    enable  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("reset_mid_vec", 32'(dut_vec), 32'(RST_VEC));
    x0 = xlat_cnt;
    tick();
    reset_n = 1'b1;
    repeat (50) tick();
    check("no_xlat_after_reset", 32'(xlat_cnt - x0), 32'd0);

    // Randomized enable toggling and occasional resets, traced against the model.
    repeat (6000) begin
      tick();
      reset_n = 1'b1;
      if ($urandom_range(0, 99) < 4) enable = ~enable;
      if ($urandom_range(0, 1999) < 3) begin
        reset_n = 1'b0;
        #1;
        check("rand_reset_vec", 32'(dut_vec), 32'(RST_VEC));
      end
    end
    tick();
    reset_n = 1'b1;
    enable  = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/panel_scan_controller.md
# panel_scan_controller

Sequencer for the per-colour PWM serialiser chain on the cube panels. Steps the shared PWM time base, pulses the serialiser's parallel-load and shift strobes, and drives the panel-side serial clock, latch and blank lines so each 16-column word reaches the panel drivers once per PWM step. One instance drives all three colour lanes in lockstep, since the lanes share `pwm_time`, `shift` and the load strobes.

## Interface
- `SR_WIDTH`, 16: bits per panel word; shift count per step.
- `PWM_MAX`, 255: last `pwm_time` value before wrap to 0.
- `CLK_DIV`, 1: `clk` cycles per `sclk` half-period (≥1).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run scanning; sampled only in IDLE and ADVANCE.
- `pwm_time`  out  8  PWM compare value to the lanes.
- `load_led_vals`  out  1  one-cycle parallel load of comparator word.
- `load_brightness`  out  1  one-cycle parallel load of brightness word (macro-gated).
- `shift`  out  1  one-cycle serialiser shift strobe.
- `sclk`  out  1  panel serial clock.
- `xlat`  out  1  panel latch pulse.
- `blank`  out  1  panel blank (1 = LEDs off).
- `mode_sel`  out  1  panel register select: 0 = grayscale, 1 = brightness.
- `frame_start`  out  1  one-cycle pulse when `pwm_time` wraps to 0.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, BIT_LO, BIT_HI, LATCH, ADVANCE (plus BLOAD, BBIT_LO, BBIT_HI, BLATCH under the macro).
- IDLE: `blank`=1. If `enable`=1, go to LOAD (or BLOAD when the macro is on and `pwm_time`=0).
- LOAD: `load_led_vals`=1 for one cycle. Clear bit counter. Go to BIT_LO.
- BIT_LO: `sclk`=0 for CLK_DIV cycles, then BIT_HI.
- BIT_HI: `sclk`=1 for CLK_DIV cycles. `shift`=1 on the last of those cycles.
  - If bit counter = SR_WIDTH-1, go to LATCH.
  - Otherwise increment the counter and go to BIT_LO.
- LATCH: `xlat`=1 for one cycle, `sclk`=0. Go to ADVANCE.
- ADVANCE:
  - If `pwm_time`=PWM_MAX: set `pwm_time` to 0 and pulse `frame_start`. Otherwise increment `pwm_time`.
  - Then, if `enable`=0, go to IDLE. Otherwise go to LOAD, or BLOAD when the new `pwm_time`=0 and the macro is on.
- `blank`=0 in every state except IDLE. The panel keeps its latched word while the next word is shifted in.
- `pwm_time` arithmetic: 8-bit unsigned, no carry out. PWM_MAX > 255 is illegal.
- `enable` deasserted mid-word has no effect until ADVANCE. The current word always completes and latches.

## Timing
- Reset values: `pwm_time`=0, `blank`=1, `sclk`=0, `mode_sel`=0; all strobes 0; `busy`=0; state IDLE; bit counter 0.
- Reset mid-word: all outputs return to reset values immediately. The partial word is discarded and never latched.
- Serial data is valid on the cycle after LOAD. The first `sclk` rise is CLK_DIV cycles after that.
- Data changes on the edge after `shift`, which coincides with `sclk` falling.
- Step period: 3 + 2·SR_WIDTH·CLK_DIV cycles (35 at defaults). Frame period: (PWM_MAX+1) × step period.
- At most one of `load_led_vals`, `load_brightness`, `shift`, `xlat` is high in any cycle.

## Configuration
- `PANEL_BRIGHTNESS_LOAD_EN` defined:
  - At each frame start, before the grayscale LOAD, run BLOAD → 16 × (BBIT_LO, BBIT_HI) → BLATCH.
  - This pass uses `load_brightness` in place of `load_led_vals`, with `mode_sel`=1 throughout. BLATCH pulses `xlat`, then goes to LOAD with `pwm_time` still 0.
  - Adds 2 + 2·SR_WIDTH·CLK_DIV cycles per frame.
- Macro undefined: brightness states are absent, `load_brightness` and `mode_sel` are tied to 0.

## Structure
- Shared package `panel_pkg`: state enumeration, `PWM_W`=8, default SR_WIDTH and CLK_DIV constants.
- One sub-module, `scan_bit_timer`:
  - Holds the CLK_DIV half-period counter and the bit counter.
  - Outputs `half_done` and `word_done` to the controller FSM.

## Test plan
- Reset, `enable`=0 → `blank`=1, `pwm_time`=0, no strobes for 100 cycles.
- `enable`=1, CLK_DIV=1 → first LOAD 1 cycle after enable. Exactly 16 `shift` and 16 `sclk` rises, then `xlat`; next LOAD 35 cycles after the first.
- Run through wrap → `pwm_time` goes 255→0 with one `frame_start` pulse. Frame period = 256×35 = 8960 cycles.
- Deassert `enable` mid-shift (bit 7) → word completes, `xlat` fires, `pwm_time` increments once, then IDLE with `blank`=1.
- Assert `reset_n`=0 at bit 10 → all outputs at reset values within the same cycle; no `xlat` afterwards until a fresh LOAD.
- With the macro defined, CLK_DIV=2 → at `pwm_time`=0, the `load_brightness` pass runs with `mode_sel`=1 and 16 shifts, then `xlat`, then the grayscale LOAD; frame period grows by 66 cycles.
